// File: rtl/or_logic_unit_seq_if.sv
`default_nettype none
// ============================================================================
// or_logic_unit_seq_if : start/operand/result bundle for or_logic_unit_seq
// Rev 1.0
// ============================================================================
interface or_logic_unit_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             zero;

  modport master (output start, op, a, b, input busy, done, y, zero);
  modport slave  (input start, op, a, b, output busy, done, y, zero);
endinterface
`default_nettype wire

// File: rtl/or_logic_unit_seq.sv
`default_nettype none
// ============================================================================
// or_logic_unit_seq : multi-cycle bitwise logic unit, SLICE bits per clock
// Rev 1.0
// ============================================================================
module or_logic_unit_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  or_logic_unit_seq_if.slave    bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   a_q,     a_d;
  logic [WIDTH-1:0]   b_q,     b_d;
  logic [1:0]         op_q,    op_d;
  logic [WIDTH-1:0]   r_q,     r_d;
  logic [WIDTH-1:0]   y_q,     y_d;
  logic               zero_q,  zero_d;

  logic [SLICE-1:0]   slice_res [NSLICE];
  logic [WIDTH-1:0]   r_merged;

  function automatic logic [SLICE-1:0] slice_op(
    input logic [1:0]       op,
    input logic [SLICE-1:0] sa,
    input logic [SLICE-1:0] sb
  );
    logic [SLICE-1:0] res;
    case (op)
      OP_OR:   res = sa | sb;
      OP_AND:  res = sa & sb;
      OP_XOR:  res = sa ^ sb;
      OP_NOR:  res = ~(sa | sb);
      default: res = '0;
    endcase
    return res;
  endfunction

  // Every slice has its own independent logic cell; the counter only picks which one is committed.
  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    assign slice_res[s] = slice_op(op_q, a_q[s*SLICE +: SLICE], b_q[s*SLICE +: SLICE]);
  end

  always_comb begin
    r_merged = r_q;
    for (int s = 0; s < NSLICE; s++) begin
      if (cnt_q == CNT_W'(s)) begin
        r_merged[s*SLICE +: SLICE] = slice_res[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      r_q     <= '0;
      y_q     <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      r_q     <= r_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    r_d     = r_q;
    y_d     = y_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_BUSY;
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          cnt_d   = '0;
          r_d     = '0;
        end
      end
      S_BUSY: begin
        r_d = r_merged;
        if (cnt_q == CNT_LAST) begin
          // y/zero are only published here so they stay stable for the whole operation.
          state_d = S_DONE;
          cnt_d   = '0;
          y_d     = r_merged;
          zero_d  = (r_merged == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.y    = y_q;
  assign bus.zero = zero_q;

endmodule
`default_nettype wire
